prt_tx_drain: RTL and testbench

PRT_TX_DRAIN -- requirements
Module: prt_tx_drain

---
 rtl/prt_tx_drain.sv | 222 ++++++++++++++++++++++
 tb/tb_prt_tx_drain.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_tx_drain.sv
// prt_tx_drain
//   Drains frames held in PRT slots. Transmit requests (slot indices) are
//   queued in a small FIFO. Each request is streamed out one byte at a time:
//   the slot is opened with a start pulse, then bytes are requested one at a
//   time, and each returned byte is presented on the m_* output. Only one
//   byte request is outstanding at any time.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   tx_req_valid/_slot    request to transmit a slot; tx_req_ready = queue not full
//   prt_start_rd          one-cycle pulse: begin reading prt_slot
//   prt_rd_req            one-cycle pulse: request the next byte of prt_slot
//   prt_slot              slot currently owned
//   prt_rd_valid/_data/_last  byte response from the PRT (used only in WAIT)
//   prt_invalidate        one-cycle pulse: invalidate prt_slot (abort/oversize)
//   abort                 drop the frame in flight
//   m_valid/_data/_last/m_ready  byte output with ready/valid handshake
//   busy                  FSM not idle
//   frames_sent           completed frame count, wraps
//   oversize_err          sticky: a frame reached MAX_FRAME bytes without last
//
// States
//   IDLE  | waiting for a queued request
//   START | prt_start_rd pulse for the slot just popped
//   REQ   | prt_rd_req pulse for the next byte
//   WAIT  | waiting (unbounded) for the byte response
//   OUT   | byte held on m_* until m_ready

module prt_tx_drain #(
  parameter int TABLE_SIZE = 2,
  parameter int IDX_W      = 1,
  parameter int QDEPTH     = 4,
  parameter int MAX_FRAME  = 1518
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_req_valid,
  input  logic [IDX_W-1:0] tx_req_slot,
  output logic             tx_req_ready,
  output logic             prt_start_rd,
  output logic             prt_rd_req,
  output logic [IDX_W-1:0] prt_slot,
  input  logic             prt_rd_valid,
  input  logic [7:0]       prt_rd_data,
  input  logic             prt_rd_last,
  output logic             prt_invalidate,
  input  logic             abort,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [15:0]      frames_sent,
  output logic             oversize_err
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  prt_slot_q;
  logic [10:0]       byte_cnt_q;
  logic [10:0]       byte_cnt_d;
  logic              prt_start_rd_q;
  logic              prt_rd_req_q;
  logic              prt_invalidate_q;
  logic              m_valid_q;
  logic [7:0]        m_data_q;
  logic              m_last_q;
  logic [15:0]       frames_sent_q;
  logic              oversize_err_q;
  logic              at_max;

  // TABLE_SIZE only bounds the legal slot values; the logic needs just IDX_W.
  logic [31:0]       unused_table_size;
  assign unused_table_size = TABLE_SIZE;

  // ---------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  q_mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  q_cnt_q;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q_full       = (q_cnt_q == CNT_W'(QDEPTH));
  assign q_empty      = (q_cnt_q == '0);
  assign tx_req_ready = !q_full;
  assign q_push       = tx_req_valid && !q_full;
  // Must match the IDLE branch of the FSM exactly (abort is ignored in IDLE).
  assign q_pop        = (state_q == ST_IDLE) && !q_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (q_push) begin
        q_mem[wr_ptr_q] <= tx_req_slot;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (q_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({q_push, q_pop})
        2'b10:   q_cnt_q <= q_cnt_q + CNT_W'(1);
        2'b01:   q_cnt_q <= q_cnt_q - CNT_W'(1);
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------
  assign byte_cnt_d = byte_cnt_q + 11'd1;
  assign at_max     = (byte_cnt_d == MAX_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      prt_slot_q       <= '0;
      byte_cnt_q       <= '0;
      prt_start_rd_q   <= 1'b0;
      prt_rd_req_q     <= 1'b0;
      prt_invalidate_q <= 1'b0;
      m_valid_q        <= 1'b0;
      m_data_q         <= '0;
      m_last_q         <= 1'b0;
      frames_sent_q    <= '0;
      oversize_err_q   <= 1'b0;
    end else begin
      prt_start_rd_q   <= 1'b0;
      prt_rd_req_q     <= 1'b0;
      prt_invalidate_q <= 1'b0;

      // Abort outranks any same-cycle response or handshake.
      if (abort && (state_q != ST_IDLE)) begin
        prt_invalidate_q <= 1'b1;
        m_valid_q        <= 1'b0;
        state_q          <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!q_empty) begin
              prt_slot_q     <= q_mem[rd_ptr_q];
              byte_cnt_q     <= '0;
              prt_start_rd_q <= 1'b1;
              state_q        <= ST_START;
            end
          end
          ST_START: begin
            prt_rd_req_q <= 1'b1;
            state_q      <= ST_REQ;
          end
          ST_REQ: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (prt_rd_valid) begin
              m_data_q   <= prt_rd_data;
              m_valid_q  <= 1'b1;
              m_last_q   <= prt_rd_last | at_max;
              byte_cnt_q <= byte_cnt_d;
              // Frame truncated at the size limit: flag it and release the slot.
              if (at_max && !prt_rd_last) begin
                oversize_err_q   <= 1'b1;
                prt_invalidate_q <= 1'b1;
              end
              state_q <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (m_ready) begin
              m_valid_q <= 1'b0;
              if (m_last_q) begin
                frames_sent_q <= frames_sent_q + 16'd1;
                state_q       <= ST_IDLE;
              end else begin
                prt_rd_req_q <= 1'b1;
                state_q      <= ST_REQ;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign prt_start_rd   = prt_start_rd_q;
  assign prt_rd_req     = prt_rd_req_q;
  assign prt_slot       = prt_slot_q;
  assign prt_invalidate = prt_invalidate_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign m_last         = m_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign frames_sent    = frames_sent_q;
  assign oversize_err   = oversize_err_q;

endmodule

// File: tb/tb_prt_tx_drain.sv
// Testbench for prt_tx_drain: table of frame vectors plus directed
// sequences for reset, abort, queue-full, oversize and counter wrap.

module tb_prt_tx_drain;

  localparam int MAXF = 1518;

  logic        clk;
  logic        reset;
  logic        tx_req_valid;
  logic [0:0]  tx_req_slot;
  logic        tx_req_ready;
  logic        prt_start_rd;
  logic        prt_rd_req;
  logic [0:0]  prt_slot;
  logic        prt_rd_valid;
  logic [7:0]  prt_rd_data;
  logic        prt_rd_last;
  logic        prt_invalidate;
  logic        abort;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic [15:0] frames_sent;
  logic        oversize_err;

  int          n_tests;
  int          n_fail;
  int          n_req;
  int          n_start;
  int          n_inv;
  logic [15:0] exp_fs;

  prt_tx_drain dut (
    .clk            (clk),
    .reset          (reset),
    .tx_req_valid   (tx_req_valid),
    .tx_req_slot    (tx_req_slot),
    .tx_req_ready   (tx_req_ready),
    .prt_start_rd   (prt_start_rd),
    .prt_rd_req     (prt_rd_req),
    .prt_slot       (prt_slot),
    .prt_rd_valid   (prt_rd_valid),
    .prt_rd_data    (prt_rd_data),
    .prt_rd_last    (prt_rd_last),
    .prt_invalidate (prt_invalidate),
    .abort          (abort),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy),
    .frames_sent    (frames_sent),
    .oversize_err   (oversize_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prt_rd_req)     n_req   <= n_req + 1;
    if (prt_start_rd)   n_start <= n_start + 1;
    if (prt_invalidate) n_inv   <= n_inv + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int slot, input logic exp_rdy);
    tx_req_slot  = 1'(slot);
    tx_req_valid = 1'b1;
    #1;
    check("tx_req_ready", 32'(tx_req_ready), 32'(exp_rdy));
    @(negedge clk);
    tx_req_valid = 1'b0;
  endtask

  task automatic wait_req(output int t);
    t = 0;
    while (!prt_rd_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", 32'(prt_rd_req), 32'd1);
  endtask

  // Acts as the PRT for one frame and consumes it on the m_* side.
  task automatic run_frame(input int slot, input int nbytes, input logic [7:0] base,
                           input int rdly, input int mdly, input bit give_last,
                           input bit junk, input bit in_wait);
    int t;
    int req0;
    int st0;
    logic [7:0] d;
    logic el;
    logic einv;
    req0 = n_req;
    st0  = n_start;
    if (!in_wait) begin
      t = 0;
      while (!prt_start_rd && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("start_seen", 32'(prt_start_rd), 32'd1);
      if (!prt_start_rd) return;
      check("start_slot", 32'(prt_slot), 32'(slot));
    end
    for (int b = 0; b < nbytes; b++) begin
      if (!(in_wait && b == 0)) begin
        wait_req(t);
        if (!prt_rd_req) return;
        if (b > 0) check("byte_period", 32'(t), 32'd0);
        if (junk) begin
          prt_rd_valid = 1'b1;
          prt_rd_data  = 8'hEE;
          prt_rd_last  = 1'b1;
        end
        @(negedge clk);
        prt_rd_valid = 1'b0;
        prt_rd_last  = 1'b0;
      end
      repeat (rdly) @(negedge clk);
      d    = base + 8'(b);
      el   = (give_last && b == nbytes - 1) || (b + 1 == MAXF);
      einv = (!give_last && b + 1 == MAXF);
      prt_rd_valid = 1'b1;
      prt_rd_data  = d;
      prt_rd_last  = give_last && (b == nbytes - 1);
      @(negedge clk);
      prt_rd_valid = 1'b0;
      prt_rd_last  = 1'b0;
      check("m_valid_up", 32'(m_valid), 32'd1);
      check("m_data", 32'(m_data), 32'(d));
      check("m_last", 32'(m_last), 32'(el));
      check("invalidate_at_byte", 32'(prt_invalidate), 32'(einv));
      for (int s = 0; s < mdly; s++) begin
        m_ready = 1'b0;
        @(negedge clk);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_data", 32'(m_data), 32'(d));
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("m_valid_down", 32'(m_valid), 32'd0);
    end
    exp_fs = exp_fs + 16'd1;
    check("frames_sent", 32'(frames_sent), 32'(exp_fs));
    check("req_count", 32'(n_req - req0), 32'(nbytes - (in_wait ? 1 : 0)));
    check("start_count", 32'(n_start - st0), in_wait ? 32'd0 : 32'd1);
  endtask

  typedef struct {
    int         slot;
    int         nbytes;
    logic [7:0] base;
    int         rdly;
    int         mdly;
    bit         junk;
    int         exp_fs_after;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t;
    int inv0;

    vt[0] = '{slot: 1, nbytes: 3, base: 8'hA1, rdly: 0,  mdly: 0,  junk: 1'b0, exp_fs_after: 1};
    vt[1] = '{slot: 0, nbytes: 1, base: 8'h10, rdly: 0,  mdly: 0,  junk: 1'b0, exp_fs_after: 2};
    vt[2] = '{slot: 1, nbytes: 4, base: 8'h20, rdly: 20, mdly: 10, junk: 1'b0, exp_fs_after: 3};
    vt[3] = '{slot: 0, nbytes: 2, base: 8'hF0, rdly: 3,  mdly: 2,  junk: 1'b1, exp_fs_after: 4};
    vt[4] = '{slot: 1, nbytes: 5, base: 8'h7E, rdly: 1,  mdly: 0,  junk: 1'b1, exp_fs_after: 5};

    n_tests = 0; n_fail = 0; n_req = 0; n_start = 0; n_inv = 0; exp_fs = 16'd0;
    reset = 1'b1; tx_req_valid = 1'b0; tx_req_slot = 1'b0;
    prt_rd_valid = 1'b0; prt_rd_data = 8'h00; prt_rd_last = 1'b0;
    abort = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_tx_req_ready", 32'(tx_req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    check("rst_oversize_err", 32'(oversize_err), 32'd0);
    check("rst_prt_slot", 32'(prt_slot), 32'd0);
    check("rst_pulses", 32'({prt_start_rd, prt_rd_req, prt_invalidate}), 32'd0);

    // Table of frames
    for (int i = 0; i < 5; i++) begin
      push(vt[i].slot, 1'b1);
      run_frame(vt[i].slot, vt[i].nbytes, vt[i].base, vt[i].rdly, vt[i].mdly,
                1'b1, vt[i].junk, 1'b0);
      check("vec_frames_sent", 32'(frames_sent), 32'(vt[i].exp_fs_after));
      check("vec_busy_after", 32'(busy), 32'd0);
    end

    // Reset in the middle of a frame: no invalidate, counters cleared
    inv0 = n_inv;
    push(1, 1'b1);
    wait_req(t);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_fs = 16'd0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frames_sent", 32'(frames_sent), 32'd0);
    check("mid_rst_prt_slot", 32'(prt_slot), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_no_invalidate", 32'(n_inv - inv0), 32'd0);

    // Abort in IDLE is ignored
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_invalidate", 32'(n_inv - inv0), 32'd0);
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Abort during WAIT on slot 0 (with a same-cycle response), slot 1 follows
    push(0, 1'b1);
    push(1, 1'b1);
    wait_req(t);
    @(negedge clk);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    prt_rd_valid = 1'b1; prt_rd_data = 8'h55; prt_rd_last = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    prt_rd_valid = 1'b0; prt_rd_last = 1'b0;
    check("abort_invalidate", 32'(prt_invalidate), 32'd1);
    check("abort_slot", 32'(prt_slot), 32'd0);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_frames_sent", 32'(frames_sent), 32'(exp_fs));
    run_frame(1, 2, 8'h30, 0, 0, 1'b1, 1'b0, 1'b0);
    check("abort_inv_count", 32'(n_inv - inv0), 32'd1);

    // Abort in OUT beats a same-cycle m_ready on the last byte
    push(1, 1'b1);
    wait_req(t);
    @(negedge clk);
    prt_rd_valid = 1'b1; prt_rd_data = 8'h99; prt_rd_last = 1'b1;
    @(negedge clk);
    prt_rd_valid = 1'b0; prt_rd_last = 1'b0;
    check("out_abort_pre_last", 32'(m_last), 32'd1);
    abort = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; m_ready = 1'b0;
    check("out_abort_invalidate", 32'(prt_invalidate), 32'd1);
    check("out_abort_slot", 32'(prt_slot), 32'd1);
    check("out_abort_m_valid", 32'(m_valid), 32'd0);
    check("out_abort_frames_sent", 32'(frames_sent), 32'(exp_fs));
    check("out_abort_busy", 32'(busy), 32'd0);

    // Queue full: frame 0 stalled in WAIT, four pushes fill, fifth refused
    push(0, 1'b1);
    wait_req(t);
    @(negedge clk);
    push(1, 1'b1);
    push(0, 1'b1);
    push(1, 1'b1);
    push(1, 1'b1);
    push(0, 1'b0);
    run_frame(0, 2, 8'h40, 0, 0, 1'b1, 1'b0, 1'b1);
    run_frame(1, 1, 8'h50, 0, 0, 1'b1, 1'b0, 1'b0);
    run_frame(0, 2, 8'h60, 0, 1, 1'b1, 1'b0, 1'b0);
    run_frame(1, 1, 8'h70, 2, 0, 1'b1, 1'b0, 1'b0);
    run_frame(1, 1, 8'h80, 0, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("full_fifth_dropped", 32'(busy), 32'd0);

    // Oversize: PRT never signals last
    inv0 = n_inv;
    check("pre_oversize_err", 32'(oversize_err), 32'd0);
    push(1, 1'b1);
    run_frame(1, MAXF, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    check("oversize_err", 32'(oversize_err), 32'd1);
    check("oversize_inv_count", 32'(n_inv - inv0), 32'd1);
    check("oversize_busy", 32'(busy), 32'd0);

    // frames_sent wrap
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    @(negedge clk);
    exp_fs = 16'hFFFF;
    check("preload_frames_sent", 32'(frames_sent), 32'h0000FFFF);
    push(0, 1'b1);
    run_frame(0, 1, 8'hC3, 0, 0, 1'b1, 1'b0, 1'b0);
    check("wrap_frames_sent", 32'(frames_sent), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
